key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_cond_pkg.sv | 9 +
 rtl/key_channel.sv | 88 ++++++++
 rtl/key_conditioner.sv | 47 ++++
 tb/tb_key_conditioner.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared debounce state encoding and default parameters for key_conditioner
package key_cond_pkg;
  typedef enum logic [1:0] {IDLE, DEB_ON, PRESSED, DEB_OFF} key_state_t;
  localparam int DEF_N_KEYS = 2;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY = 50;
  localparam int DEF_REPEAT_RATE = 10;
endpackage

// File: rtl/key_channel.sv
// key_channel: one key's synchronizer, debounce FSM and, with KEY_COND_REPEAT_EN, auto-repeat counter
module key_channel
  import key_cond_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef KEY_COND_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE = DEF_REPEAT_RATE
`endif
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key,
  output logic fire,
  output logic held
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit QUICK = DEBOUNCE_CYCLES == 1;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  key_state_t state;
  logic s;
  assign s = sync[SYNC_STAGES-1];
`ifdef KEY_COND_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  logic [RW-1:0] rcnt, rlim;
  logic rep;
  assign rlim = rep ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1);
`endif
  // The transition fires on the edge that sees the DEBOUNCE_CYCLES-th consecutive stable sample
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync <= '0;
      state <= IDLE;
      cnt <= '0;
      fire <= 1'b0;
      held <= 1'b0;
`ifdef KEY_COND_REPEAT_EN
      rcnt <= '0;
      rep <= 1'b0;
`endif
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key};
      fire <= 1'b0;
`ifdef KEY_COND_REPEAT_EN
      if (state == IDLE || state == DEB_ON) begin
        rcnt <= '0;
        rep <= 1'b0;
      end
`endif
      case (state)
        IDLE: if (s) begin
          state <= QUICK ? PRESSED : DEB_ON;
          cnt <= CW'(1);
          fire <= QUICK;
          held <= QUICK;
        end
        DEB_ON: if (!s) state <= IDLE;
        else if (cnt == LAST) begin
          state <= PRESSED;
          fire <= 1'b1;
          held <= 1'b1;
        end else cnt <= cnt + 1'b1;
        PRESSED: if (!s) begin
          state <= QUICK ? IDLE : DEB_OFF;
          cnt <= CW'(1);
          held <= !QUICK;
        end
`ifdef KEY_COND_REPEAT_EN
        else if (rcnt == rlim) begin
          fire <= 1'b1;
          rcnt <= '0;
          rep <= 1'b1;
        end else rcnt <= rcnt + 1'b1;
`endif
        DEB_OFF: if (s) state <= PRESSED;
        else if (cnt == LAST) begin
          state <= IDLE;
          held <= 1'b0;
        end else cnt <= cnt + 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: N_KEYS debounced key channels with gated press pulses; KEY_COND_REPEAT_EN adds auto-repeat
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int N_KEYS = DEF_N_KEYS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE = DEF_REPEAT_RATE
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] Key,
  input  logic              Enable,
  output logic [N_KEYS-1:0] Pulse,
  output logic [N_KEYS-1:0] Held,
  output logic              SimulPress
);
  if (N_KEYS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("key_conditioner: parameter out of range");
  end
  logic [N_KEYS-1:0] fire;
  logic en_q;
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_COND_REPEAT_EN
      ,
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE(REPEAT_RATE)
`endif
    ) u_ch (
      .Clock(Clock),
      .Reset(Reset),
      .key(Key[i]),
      .fire(fire[i]),
      .held(Held[i])
    );
  end
  // Enable is registered on the same edge as the channel fire flops so the gate lines up with the event
  always_ff @(posedge Clock) begin
    en_q <= Reset ? 1'b0 : Enable;
  end
  assign Pulse = fire & {N_KEYS{en_q}};
  assign SimulPress = |(Pulse & (Pulse - N_KEYS'(1)));
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: scoreboard bench for key_conditioner with a run-length hysteresis reference model
module tb_key_conditioner;
  localparam int N = 2;
  localparam int S = 2;
  localparam int D = 4;
  localparam int RD = 50;
  localparam int RR = 10;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Enable = 1'b1;
  logic [N-1:0] Key = '0;
  logic [N-1:0] Pulse, Held;
  logic SimulPress;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [N-1:0] pulse;
    logic [N-1:0] held;
    logic simul;
  } exp_t;
  exp_t sb[$];
  logic [S-1:0] hist[N];
  int run1[N], run0[N], rc[N];
  bit mheld[N], sprev[N], first[N];

  always #5 Clock = ~Clock;

  key_conditioner #(
    .N_KEYS(N),
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Key(Key),
    .Enable(Enable),
    .Pulse(Pulse),
    .Held(Held),
    .SimulPress(SimulPress)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge Clock);
  endtask

  // Reference: the synced sample is the key as it was S edges ago; Held is a hysteresis on
  // runs of D equal samples; a press event is Held rising; repeats count edges spent pressed.
  always @(posedge Clock) begin : model
    exp_t e;
    bit ev;
    logic s;
    e = '0;
    if (Reset) begin
      for (int c = 0; c < N; c++) begin
        hist[c] = '0;
        run1[c] = 0;
        run0[c] = 0;
        rc[c] = 0;
        mheld[c] = 1'b0;
        sprev[c] = 1'b0;
        first[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        s = hist[c][S-1];
        hist[c] = {hist[c][S-2:0], Key[c]};
        run1[c] = s ? run1[c] + 1 : 0;
        run0[c] = s ? 0 : run0[c] + 1;
        ev = 1'b0;
        if (!mheld[c] && run1[c] >= D) begin
          mheld[c] = 1'b1;
          ev = 1'b1;
          rc[c] = 0;
          first[c] = 1'b1;
        end else if (mheld[c] && run0[c] >= D) mheld[c] = 1'b0;
`ifdef KEY_COND_REPEAT_EN
        else if (mheld[c] && sprev[c] && s) begin
          rc[c]++;
          if (rc[c] == (first[c] ? RD : RR)) begin
            ev = 1'b1;
            rc[c] = 0;
            first[c] = 1'b0;
          end
        end
`endif
        sprev[c] = s;
        e.pulse[c] = ev & Enable;
        e.held[c] = mheld[c];
      end
    end
    e.simul = $countones(e.pulse) > 1;
    sb.push_back(e);
  end

  always @(negedge Clock) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_pulse", Pulse, e.pulse);
      check("sb_held", Held, e.held);
      check("sb_simul", SimulPress, e.simul);
    end
  end

  initial begin
    tick(3);
    Reset = 1'b0;
    check("reset_outputs", {Pulse, Held, SimulPress}, 0);
    Key[0] = 1'b1;
    tick(5);
    check("lat_pulse_early", Pulse[0], 0);
    tick();
    check("lat_pulse", Pulse[0], 1);
    check("lat_held", Held[0], 1);
    tick();
    check("lat_pulse_once", Pulse[0], 0);
    tick(13);
    Key[0] = 1'b0;
    tick(5);
    check("rel_held_kept", Held[0], 1);
    tick();
    check("rel_held_drop", Held[0], 0);
    tick(5);
    Key[1] = 1'b1;
    tick(2);
    Key[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("glitch", {Pulse[1], Held[1]}, 0);
    end
    Key = 2'b11;
    tick(6);
    check("simul_pulse", Pulse, 2'b11);
    check("simul_flag", SimulPress, 1);
    tick();
    check("simul_once", {Pulse, SimulPress}, 0);
    tick(8);
    Key = '0;
    tick(8);
    Enable = 1'b0;
    Key[0] = 1'b1;
    tick(6);
    check("gate_held", Held[0], 1);
    check("gate_pulse", Pulse[0], 0);
    Enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("gate_lost", Pulse[0], 0);
    end
    Key[0] = 1'b0;
    tick(8);
    Key[0] = 1'b1;
    tick(4);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst_clear", {Pulse, Held, SimulPress}, 0);
    tick(5);
    check("rst_pulse_early", Pulse[0], 0);
    tick();
    check("rst_pulse", Pulse[0], 1);
    tick();
    check("rst_pulse_once", Pulse[0], 0);
    tick(8);
    Key[0] = 1'b0;
    tick(8);
`ifdef KEY_COND_REPEAT_EN
    begin
      int hits[$];
      int want[4];
      want = '{6, 56, 66, 76};
      Key[0] = 1'b1;
      for (int k = 1; k <= 90; k++) begin
        tick();
        if (Pulse[0]) hits.push_back(k);
        if (k == 80) Key[0] = 1'b0;
      end
      check("rep_count", hits.size(), 4);
      for (int i = 0; i < 4; i++) check("rep_at", i < hits.size() ? hits[i] : -1, want[i]);
      tick(8);
    end
`endif
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(0, 7) == 0) Key[c] = ~Key[c];
      Enable = $urandom_range(0, 7) != 0;
      Reset = $urandom_range(0, 299) == 0;
      tick();
    end
    Reset = 1'b0;
    Key = '0;
    tick(12);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
